// File: rtl/exec_seq_pkg.sv
// Shared FSM state type and ALU constants for the exec_sequencer block.
package exec_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EXE  = 3'd1,
    PC4  = 3'd2,
    SHL  = 3'd3,
    BTGT = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [3:0]  ALU_AND = 4'b0000;
  localparam logic [3:0]  ALU_OR  = 4'b0001;
  localparam logic [3:0]  ALU_ADD = 4'b0010;
  localparam logic [3:0]  ALU_SLL = 4'b0011;
  localparam logic [3:0]  ALU_SUB = 4'b0110;
  localparam logic [63:0] PC_STEP = 64'd4;

endpackage

// File: rtl/ALU.sv
// 64-bit combinational ALU shared by every step of the exec_sequencer.
module ALU
  import exec_seq_pkg::*;
(
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [3:0]  alu_control_signal,
  output logic [63:0] alu_result
);

  // Unknown opcodes produce zero; shifts use only the low six bits of b.
  always_comb begin
    alu_result = '0;
    case (alu_control_signal)
      ALU_AND: alu_result = a & b;
      ALU_OR:  alu_result = a | b;
      ALU_ADD: alu_result = a + b;
      ALU_SLL: alu_result = a << b[5:0];
      ALU_SUB: alu_result = a - b;
      default: alu_result = '0;
    endcase
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction execute step built around one time-shared ALU.
// Optional EXEC_SEQ_PERF_CNT_EN adds saturating op_count/taken_count outputs.
module exec_sequencer
  import exec_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  alu_control_signal,
  input  logic [63:0] rd1,
  input  logic [63:0] rd2,
  input  logic [63:0] PC,
  input  logic [63:0] immediate,
  input  logic        Branch,
  output logic        busy,
  output logic        done,
  output logic [63:0] alu_output,
  output logic [63:0] next_PC,
  output logic        branch_taken
`ifdef EXEC_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] op_count,
  output logic [31:0] taken_count
`endif
);

  state_t      state, state_next;
  logic [63:0] rd1_q, rd2_q, pc_q, imm_q, shifted_q;
  logic [3:0]  op_q;
  logic        br_q, zero_q;
  logic [63:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_op;
  logic        accept;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  // Operand/op steering: EXE uses the latched instruction, other steps reuse the ALU.
  always_comb begin
    alu_a  = rd1_q;
    alu_b  = rd2_q;
    alu_op = op_q;
    case (state)
      PC4: begin
        alu_a  = pc_q;
        alu_b  = PC_STEP;
        alu_op = ALU_ADD;
      end
      SHL: begin
        alu_a  = imm_q;
        alu_b  = 64'd1;
        alu_op = ALU_SLL;
      end
      BTGT: begin
        alu_a  = pc_q;
        alu_b  = shifted_q;
        alu_op = ALU_ADD;
      end
      default: ;
    endcase
  end

  ALU u_alu (
    .a                  (alu_a),
    .b                  (alu_b),
    .alu_control_signal (alu_op),
    .alu_result         (alu_y)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EXE;
      EXE:     state_next = PC4;
      PC4:     state_next = (br_q && zero_q) ? SHL : DONE;
      SHL:     state_next = BTGT;
      BTGT:    state_next = DONE;
      DONE:    state_next = start ? EXE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Operands are captured only on acceptance, so they stay frozen through the sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd1_q        <= '0;
      rd2_q        <= '0;
      pc_q         <= '0;
      imm_q        <= '0;
      op_q         <= '0;
      br_q         <= 1'b0;
      zero_q       <= 1'b0;
      shifted_q    <= '0;
      alu_output   <= '0;
      next_PC      <= '0;
      branch_taken <= 1'b0;
    end else begin
      if (accept) begin
        rd1_q <= rd1;
        rd2_q <= rd2;
        pc_q  <= PC;
        imm_q <= immediate;
        op_q  <= alu_control_signal;
        br_q  <= Branch;
      end
      case (state)
        EXE: begin
          alu_output <= alu_y;
          zero_q     <= (alu_y == 64'd0);
        end
        PC4: begin
          next_PC      <= alu_y;
          branch_taken <= br_q && zero_q;
        end
        SHL:     shifted_q <= alu_y;
        BTGT:    next_PC   <= alu_y;
        default: ;
      endcase
    end
  end

`ifdef EXEC_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_count    <= '0;
      taken_count <= '0;
    end else if (state == DONE) begin
      if (op_count != 32'hFFFF_FFFF) op_count <= op_count + 32'd1;
      if (branch_taken && (taken_count != 32'hFFFF_FFFF)) taken_count <= taken_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed self-checking bench for exec_sequencer (counter checks under EXEC_SEQ_PERF_CNT_EN).
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  alu_control_signal;
  logic [63:0] rd1, rd2, PC, immediate;
  logic        Branch;
  logic        busy, done, branch_taken;
  logic [63:0] alu_output, next_PC;
`ifdef EXEC_SEQ_PERF_CNT_EN
  logic [31:0] op_count, taken_count;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  exec_sequencer dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .alu_control_signal (alu_control_signal),
    .rd1                (rd1),
    .rd2                (rd2),
    .PC                 (PC),
    .immediate          (immediate),
    .Branch             (Branch),
    .busy               (busy),
    .done               (done),
    .alu_output         (alu_output),
    .next_PC            (next_PC),
    .branch_taken       (branch_taken)
`ifdef EXEC_SEQ_PERF_CNT_EN
    ,
    .op_count           (op_count),
    .taken_count        (taken_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one instruction, glitching start and operands mid-sequence; they must be ignored.
  task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [63:0] a,
                               input logic [63:0] b, input logic [63:0] pc, input logic [63:0] imm,
                               input logic br, input int expLat, input logic [63:0] expAlu,
                               input logic [63:0] expNext, input logic expTaken);
    int cycles = 0;
    @(negedge clk);
    alu_control_signal = op;
    rd1 = a; rd2 = b; PC = pc; immediate = imm; Branch = br;
    start = 1'b1;
    while (cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1 || cycles == 3) start = 1'b0;
      if (done) break;
      if (cycles == 2) begin
        start = 1'b1;
        rd1 = ~a; rd2 = 64'h55; PC = 64'hDEAD_0000; immediate = 64'h777; Branch = ~br;
        alu_control_signal = OP_AND;
      end
    end
    start = 1'b0;
    checkOutput({tag, "_latency"}, 64'(cycles), 64'(expLat));
    checkOutput({tag, "_alu_output"}, alu_output, expAlu);
    checkOutput({tag, "_next_PC"}, next_PC, expNext);
    checkOutput({tag, "_branch_taken"}, 64'(branch_taken), 64'(expTaken));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
    checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
    checkOutput({tag, "_hold_next_PC"}, next_PC, expNext);
  endtask

  initial begin
    int cycles;
    int doneSeen;
    rst = 1'b0; start = 1'b0; alu_control_signal = '0;
    rd1 = '0; rd2 = '0; PC = '0; immediate = '0; Branch = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_alu_output", alu_output, 64'd0);
    checkOutput("reset_next_PC", next_PC, 64'd0);
    checkOutput("reset_branch_taken", 64'(branch_taken), 64'd0);
    rst = 1'b1;

    applyStimulus("add_basic", OP_ADD, 64'd5, 64'd7, 64'h100, 64'd0, 1'b0, 3, 64'd12, 64'h104, 1'b0);
    applyStimulus("sub_taken", OP_SUB, 64'd9, 64'd9, 64'h200, 64'h10, 1'b1, 5, 64'd0, 64'h220, 1'b1);
    applyStimulus("sub_not_taken", OP_SUB, 64'd3, 64'd9, 64'h40, 64'h10, 1'b1, 3,
                  64'hFFFF_FFFF_FFFF_FFFA, 64'h44, 1'b0);

    // PC wrap with start held high: second op must follow DONE without an IDLE cycle.
    @(negedge clk);
    alu_control_signal = OP_ADD; rd1 = 64'd1; rd2 = 64'd2;
    PC = 64'hFFFF_FFFF_FFFF_FFFC; immediate = '0; Branch = 1'b0; start = 1'b1;
    cycles = 0;
    while (cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin rd1 = 64'd100; rd2 = 64'd0; PC = 64'h10; end
      if (done) break;
    end
    checkOutput("wrap_latency", 64'(cycles), 64'd3);
    checkOutput("wrap_alu_output", alu_output, 64'd3);
    checkOutput("wrap_next_PC", next_PC, 64'd0);
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_busy", 64'(busy), 64'd1);
    checkOutput("b2b_done_low", 64'(done), 64'd0);
    cycles = 1;
    while (cycles < 20 && !done) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("b2b_latency", 64'(cycles), 64'd3);
    checkOutput("b2b_alu_output", alu_output, 64'd100);
    checkOutput("b2b_next_PC", next_PC, 64'h14);
    @(negedge clk);

    // Reset during a taken branch must abort with no done pulse.
    alu_control_signal = OP_AND; rd1 = 64'hF0; rd2 = 64'h0F;
    PC = 64'h300; immediate = 64'h8; Branch = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_next_PC", next_PC, 64'd0);
    checkOutput("abort_branch_taken", 64'(branch_taken), 64'd0);
    doneSeen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checkOutput("abort_no_done", 64'(doneSeen), 64'd0);
    checkOutput("abort_wait_idle", 64'(busy), 64'd0);

    applyStimulus("after_reset", OP_ADD, 64'd20, 64'd22, 64'h1000, 64'd0, 1'b0, 3, 64'd42, 64'h1004, 1'b0);
    applyStimulus("taken_2", OP_SUB, 64'd5, 64'd5, 64'h0, 64'h8, 1'b1, 5, 64'd0, 64'h10, 1'b1);
    applyStimulus("not_taken_2", OP_ADD, 64'd1, 64'd1, 64'h80, 64'h4, 1'b1, 3, 64'd2, 64'h84, 1'b0);

`ifdef EXEC_SEQ_PERF_CNT_EN
    checkOutput("op_count_3", 64'(op_count), 64'd3);
    checkOutput("taken_count_1", 64'(taken_count), 64'd1);
    @(negedge clk);
    force dut.op_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.op_count;
    applyStimulus("sat_op", OP_ADD, 64'd2, 64'd3, 64'h8, 64'd0, 1'b0, 3, 64'd5, 64'hC, 1'b0);
    checkOutput("op_count_saturated", 64'(op_count), 64'hFFFF_FFFF);
    checkOutput("taken_count_hold", 64'(taken_count), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit, rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit, asynchronous active-low reset (0 = in reset).
REQ-003 SHALL have port start, input, 1 bit, request to execute one instruction.
REQ-004 SHALL have port alu_control_signal, input, 4 bits, main ALU operation code.
REQ-005 SHALL have ports rd1, rd2, PC and immediate, all inputs, 64 bits, with rd1/rd2 as ALU operands, PC as the instruction address and immediate as the branch offset (unshifted).
REQ-006 SHALL have port Branch, input, 1 bit, which marks the instruction as a conditional branch.
REQ-007 SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-008 SHALL have port done, output, 1 bit, a one-cycle pulse when results are valid.
REQ-009 SHALL have port alu_output, output, 64 bits, the main ALU result.
REQ-010 SHALL have port next_PC, output, 64 bits, holding PC+4 or the branch target.
REQ-011 SHALL have port branch_taken, output, 1 bit, defined as Branch AND (alu_output == 0).

Function
REQ-012 SHALL time-share one ALU instance across the main op, PC+4, immediate<<1 and PC+(immediate<<1).
REQ-013 SHALL use FSM states IDLE, EXE, PC4, SHL, BTGT and DONE.
REQ-014 SHALL accept start only in IDLE or DONE; on acceptance it latches rd1, rd2, PC, immediate, Branch and alu_control_signal, then moves to EXE.
REQ-015 SHALL ignore start in EXE, PC4, SHL and BTGT, and latched operands SHALL NOT change in those states.
REQ-016 In EXE, the ALU computes the op on the latched rd1/rd2; the result goes to alu_output, zero flag := (result == 0), and state moves to PC4.
REQ-017 In PC4, the ALU (ADD) computes PC+4 into next_PC; the FSM goes to SHL if Branch & zero, else to DONE.
REQ-018 In SHL, the ALU (SLL) computes immediate<<1 into an internal register; state moves to BTGT.
REQ-019 In BTGT, the ALU (ADD) computes PC+shifted into next_PC; state moves to DONE.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle; the FSM returns to IDLE, or goes to EXE if start is high.
REQ-021 Latency, counting the start-sampled cycle as 0: done SHALL be high in cycle 3 for a not-taken instruction and in cycle 5 for a taken one.
REQ-022 alu_output, next_PC and branch_taken SHALL hold their values from DONE until the next EXE/PC4 update.
REQ-023 All additions SHALL be 64-bit modulo 2^64, with no carry out; the shift discards bit 63.

Reset
REQ-024 When rst=0, state SHALL be IDLE, all outputs and internal registers 0, and counters 0 when compiled in.
REQ-025 Reset asserted mid-sequence SHALL abort without a done pulse; after release the block waits in IDLE for a new start.

Configuration
REQ-026 With EXEC_SEQ_PERF_CNT_EN defined, the block SHALL add outputs op_count[31:0] (+1 per done) and taken_count[31:0] (+1 per taken done), both saturating at 32'hFFFFFFFF.
REQ-027 Without EXEC_SEQ_PERF_CNT_EN, those ports and counters SHALL be absent and behaviour otherwise identical.

Structure
REQ-028 Package exec_seq_pkg SHALL hold the FSM state enum and the constants ALU_ADD=4'b0010, ALU_SLL=4'b0011 and PC_STEP=64'd4.
REQ-029 The block SHALL instantiate exactly one existing ALU sub-module (ALU: a, b, alu_control_signal, alu_result), with operand and op muxes driven by the FSM state.

Verification
REQ-030 ADD, rd1=5, rd2=7, PC=0x100, Branch=0, start pulse -> cycle 3: done=1, alu_output=12, next_PC=0x104, branch_taken=0.
REQ-031 SUB op, rd1=rd2=9, Branch=1, PC=0x200, immediate=0x10 -> cycle 5: done=1, alu_output=0, next_PC=0x220, branch_taken=1.
REQ-032 Branch=1, rd1=3, rd2=9 (SUB, nonzero), PC=0x40 -> cycle 3: done=1, next_PC=0x44, branch_taken=0.
REQ-033 PC=64'hFFFFFFFFFFFFFFFC, Branch=0 -> next_PC=0 (wrap); start held high through the sequence -> exactly one op until DONE, then back-to-back op with no IDLE cycle.
REQ-034 rst=0 in cycle 2 of a taken branch -> no done, all outputs 0; a new start after release completes normally.
REQ-035 With EXEC_SEQ_PERF_CNT_EN: 3 ops, of which 1 is taken -> op_count=3, taken_count=1; force op_count=32'hFFFFFFFF, then one more op -> it stays at 32'hFFFFFFFF.
